ytydla_conv_cact: RTL and testbench
===================================

# ytydla_conv_cact

Convolution activation stage: consumes the scalar partial-sum stream that the channel accumulator drives on `cacc2cact_dat`/`cacc2cact_valid` and applies requantisation, optional ReLU and saturation. It packs the results into memory words and writes them to the output feature buffer through a valid/ready port. The accumulator cannot be back-pressured, so the block buffers packed words in a small FIFO and flags loss with a sticky overflow flag. One layer runs per `cfg_start`.

## Interface
- `DATA_W`, `` `YTYDLA_DATA_LENGTH ``, width of the signed accumulator result.
- `OUT_W`, 8, width of one signed activation.
- `PACK`, 4, activations per memory word; power of two.
- `FIFO_DEPTH`, 8, packed words buffered; power of two.
- `ADDR_W`, 16, memory word address width.
- `ytydla_core_clk`  in  1  core clock; reset `ytydla_core_rst_n`, asynchronous, active-low.
- `ytydla_core_rst_n`  in  1  asynchronous active-low reset.
- `cfg_start`  in  1  one-cycle layer start; honoured only in IDLE.
- `cfg_out_num`  in  16  results in the layer.
- `cfg_shift`  in  5  arithmetic right-shift amount.
- `cfg_base_addr`  in  ADDR_W  first word address.
- `cacc2cact_dat`  in  DATA_W  signed accumulator result.
- `cacc2cact_valid`  in  1  result qualifier; no ready.
- `cact2mem_dat`  out  OUT_W*PACK  packed word; lane 0 is in bits [OUT_W-1:0].
- `cact2mem_addr`  out  ADDR_W  word address.
- `cact2mem_valid`  out  1  write request.
- `mem2cact_ready`  in  1  write accept.
- `cact_busy`  out  1  high in every state except IDLE.
- `cact_done`  out  1  one-cycle end-of-layer pulse.
- `cact_overflow`  out  1  sticky: a word was dropped.

## Operation
- FSM states IDLE, RUN, FLUSH, DONE. At `cfg_start` in IDLE: latch all `cfg_*` inputs, clear the result, lane and word counters and `cact_overflow`, then go to RUN. If `cfg_out_num`==0, go to DONE instead.
- `cfg_start` outside IDLE is ignored. `cacc2cact_valid` in IDLE, FLUSH or DONE is dropped, is not counted, and does not set the overflow flag.
- Stage 1 (quantise), applied to each valid result in RUN:
  - Add rounding term `1<<(shift-1)` when shift>0.
  - Arithmetic shift right by shift.
  - ReLU: a negative value becomes 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Intermediate width is DATA_W+1; no wrap is allowed.
- Stage 2 (pack): write the lane at the lane index, then increment the index. When PACK lanes are filled, or the `cfg_out_num`-th result arrives, push the word into the FIFO and clear the pack register. Lanes of a partial word are zero.
- Result counter reaching `cfg_out_num` moves RUN to FLUSH.
- FIFO is a registered array with separate read/write pointers plus a count.
  - Head drives `cact2mem_dat`; `cact2mem_valid` = not empty.
  - Pop on `cact2mem_valid && mem2cact_ready`. Data and address stay stable while the request is unaccepted.
  - Push with FIFO full and no pop in the same cycle: the word is dropped and `cact_overflow` is set. Push and pop in the same cycle when full succeeds.
- `cact2mem_addr` = `cfg_base_addr` + number of words pushed before this one. Dropped words consume an address, so later words keep their positions. Address wraps mod 2^ADDR_W.
- FLUSH lasts until the pipeline and pack register are empty, the FIFO is empty, and the last handshake is complete. FLUSH then goes to DONE, `cact_done`=1 for one cycle, then IDLE.

## Timing
- All outputs are 0 at reset. Reset mid-layer discards the pipeline and FIFO contents and returns to IDLE.
- Latency: a result completing a word, valid in cycle n, gives `cact2mem_valid` in cycle n+3 when the FIFO is empty.
- Sustained rate of one result per cycle; the output side accepts one word per cycle.
- `cact_done` occurs at least one cycle after the final handshake.

## Configuration
- `YTYDLA_CACT_RELU_EN` defined: the ReLU step is present.
- Undefined: ReLU logic is compiled out, and negative values pass through to saturation (signed output).

## Test plan
- Layer with `cfg_out_num`=4, shift=4, base 0x0100, inputs 400, 24, -32, 70000 (ReLU on) -> one write of 0x7F000219 at 0x0100, then `cact_done`. Without the macro the same stimulus -> 0x7F00FE... no: lane 2 is -2, so the write is 0x7FFE0219.
- `cfg_out_num`=6, inputs 16, 32, 48, 64, 80, 96, shift=4 -> 0x04030201 at 0x0100, then partial word 0x00000605 at 0x0101, one done pulse.
- `mem2cact_ready`=0, 40 back-to-back results of 16 (shift 4) -> 8 words buffered and `cact_overflow`=1. After ready rises -> 8 writes of 0x01010101 at 0x0100–0x0107, then done. Addresses 0x0108–0x0109 are absent.
- Random ready toggling on a 64-result layer -> no lost or duplicated words, and data/address stable while valid is high and ready is low.
- `cacc2cact_valid` pulses in IDLE, and a `cfg_start` while in RUN -> no writes and no counter change.
- Reset asserted mid-RUN with 2 words queued -> outputs 0 immediately. A following layer starts at `cfg_base_addr` with `cact_overflow`=0.

Source files
------------

// File: rtl/ytydla_conv_cact.sv
// Convolution activation stage: requantise, optional ReLU, saturate, pack, buffer.
// Define YTYDLA_CACT_RELU_EN to include the ReLU step; without it outputs are signed.
`ifndef YTYDLA_DATA_LENGTH
`define YTYDLA_DATA_LENGTH 32
`endif

module ytydla_conv_cact #(
    parameter int DATA_W     = `YTYDLA_DATA_LENGTH,
    parameter int OUT_W      = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                    ytydla_core_clk,
    input  logic                    ytydla_core_rst_n,
    input  logic                    cfg_start,
    input  logic [15:0]             cfg_out_num,
    input  logic [4:0]              cfg_shift,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [DATA_W-1:0]       cacc2cact_dat,
    input  logic                    cacc2cact_valid,
    output logic [OUT_W*PACK-1:0]   cact2mem_dat,
    output logic [ADDR_W-1:0]       cact2mem_addr,
    output logic                    cact2mem_valid,
    input  logic                    mem2cact_ready,
    output logic                    cact_busy,
    output logic                    cact_done,
    output logic                    cact_overflow
);

    localparam int WORD_W = OUT_W * PACK;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int SW     = DATA_W + 1;

    localparam logic signed [SW-1:0] QMAX =
        {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] QMIN =
        {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [15:0]        cfg_num_q, cfg_num_d;
    logic [4:0]         cfg_shift_q, cfg_shift_d;
    logic [ADDR_W-1:0]  cfg_base_q, cfg_base_d;
    logic [15:0]        res_cnt_q, res_cnt_d;

    logic               s1_vld_q, s1_vld_d;
    logic               s1_last_q, s1_last_d;
    logic [OUT_W-1:0]   s1_dat_q, s1_dat_d;

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;

    logic               push_vld_q, push_vld_d;
    logic [WORD_W-1:0]  push_dat_q, push_dat_d;
    logic [ADDR_W-1:0]  push_addr_q, push_addr_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [WORD_W-1:0]  mem_dat  [FIFO_DEPTH];
    logic [ADDR_W-1:0]  mem_addr [FIFO_DEPTH];

    logic               start;
    logic               in_acc;
    logic               in_last;
    logic               fifo_full;
    logic               fifo_pop;
    logic               fifo_push;
    logic               fifo_drop;
    logic               drained;

    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shd;
    logic signed [SW-1:0] act;
    logic [OUT_W-1:0]     q;
    logic [WORD_W-1:0]    word_v;

    assign start   = (state_q == S_IDLE) && cfg_start;
    assign in_acc  = (state_q == S_RUN) && cacc2cact_valid;
    assign in_last = in_acc && ((res_cnt_q + 16'd1) == cfg_num_q);

    assign cact2mem_valid = (cnt_q != '0);
    assign fifo_full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_pop       = cact2mem_valid && mem2cact_ready;
    assign fifo_push      = push_vld_q && (!fifo_full || fifo_pop);
    assign fifo_drop      = push_vld_q && fifo_full && !fifo_pop;

    assign drained = !s1_vld_q && !push_vld_q &&
                     (lane_q == '0) && (cnt_q == '0);

    // Head is gated so the outputs read zero whenever nothing is queued.
    assign cact2mem_dat  = cact2mem_valid ? mem_dat[rd_ptr_q]  : '0;
    assign cact2mem_addr = cact2mem_valid ? mem_addr[rd_ptr_q] : '0;
    assign cact_busy     = (state_q != S_IDLE);
    assign cact_done     = (state_q == S_DONE);
    assign cact_overflow = ovf_q;

    // Requantisation uses one extra bit so the rounding add cannot wrap.
    always_comb begin
        rnd = '0;
        if (cfg_shift_q != 5'd0) begin
            rnd = SW'(1) << (cfg_shift_q - 5'd1);
        end
        sum = $signed({cacc2cact_dat[DATA_W-1], cacc2cact_dat}) + rnd;
        shd = sum >>> cfg_shift_q;
        act = shd;
`ifdef YTYDLA_CACT_RELU_EN
        if (shd < 0) begin
            act = '0;
        end
`endif
        if (act > QMAX) begin
            q = QMAX[OUT_W-1:0];
        end else if (act < QMIN) begin
            q = QMIN[OUT_W-1:0];
        end else begin
            q = act[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_out_num == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_num_d   = cfg_num_q;
        cfg_shift_d = cfg_shift_q;
        cfg_base_d  = cfg_base_q;
        res_cnt_d   = res_cnt_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        word_cnt_d  = word_cnt_q;
        ovf_d       = ovf_q;
        push_vld_d  = 1'b0;
        push_dat_d  = push_dat_q;
        push_addr_d = push_addr_q;
        word_v      = pack_q;

        s1_vld_d  = in_acc;
        s1_last_d = in_last;
        s1_dat_d  = in_acc ? q : s1_dat_q;

        if (in_acc) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end

        if (s1_vld_q) begin
            word_v[lane_q*OUT_W +: OUT_W] = s1_dat_q;
            if ((lane_q == LANE_W'(PACK-1)) || s1_last_q) begin
                push_vld_d  = 1'b1;
                push_dat_d  = word_v;
                push_addr_d = cfg_base_q + word_cnt_q;
                word_cnt_d  = word_cnt_q + 1'b1;
                pack_d      = '0;
                lane_d      = '0;
            end else begin
                pack_d = word_v;
                lane_d = lane_q + 1'b1;
            end
        end

        if (fifo_drop) begin
            ovf_d = 1'b1;
        end

        if (start) begin
            cfg_num_d   = cfg_out_num;
            cfg_shift_d = cfg_shift;
            cfg_base_d  = cfg_base_addr;
            res_cnt_d   = '0;
            lane_d      = '0;
            pack_d      = '0;
            word_cnt_d  = '0;
            ovf_d       = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    always_ff @(posedge ytydla_core_clk) begin
        if (fifo_push) begin
            mem_dat[wr_ptr_q]  <= push_dat_q;
            mem_addr[wr_ptr_q] <= push_addr_q;
        end
    end

    always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
        if (!ytydla_core_rst_n) begin
            state_q     <= S_IDLE;
            cfg_num_q   <= '0;
            cfg_shift_q <= '0;
            cfg_base_q  <= '0;
            res_cnt_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_dat_q    <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            word_cnt_q  <= '0;
            push_vld_q  <= 1'b0;
            push_dat_q  <= '0;
            push_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_num_q   <= cfg_num_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_base_q  <= cfg_base_d;
            res_cnt_q   <= res_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_dat_q    <= s1_dat_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            word_cnt_q  <= word_cnt_d;
            push_vld_q  <= push_vld_d;
            push_dat_q  <= push_dat_d;
            push_addr_q <= push_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ytydla_conv_cact.sv
// Bench for ytydla_conv_cact: random and directed layers against a reference
// model of quantise/pack/address rules, checked on every write handshake.
module tb_ytydla_conv_cact;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_out_num = '0;
    logic [4:0]  cfg_shift = '0;
    logic [15:0] cfg_base_addr = '0;
    logic [31:0] dat = '0;
    logic        vld = 1'b0;
    logic [31:0] mdat;
    logic [15:0] maddr;
    logic        mvld;
    logic        mrdy = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;

    bit rdy_rand = 1'b0;
    bit rdy_fix = 1'b0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [15:0] exp_addr[$];
    logic [31:0] exp_dat[$];

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pd = 1'b0;
    logic [31:0] pdat = '0;
    logic [15:0] paddr = '0;

    ytydla_conv_cact #(
        .DATA_W(32),
        .OUT_W(8),
        .PACK(4),
        .FIFO_DEPTH(8),
        .ADDR_W(16)
    ) dut (
        .ytydla_core_clk(clk),
        .ytydla_core_rst_n(rst_n),
        .cfg_start(cfg_start),
        .cfg_out_num(cfg_out_num),
        .cfg_shift(cfg_shift),
        .cfg_base_addr(cfg_base_addr),
        .cacc2cact_dat(dat),
        .cacc2cact_valid(vld),
        .cact2mem_dat(mdat),
        .cact2mem_addr(maddr),
        .cact2mem_valid(mvld),
        .mem2cact_ready(mrdy),
        .cact_busy(busy),
        .cact_done(done),
        .cact_overflow(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        mrdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pd = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", mvld, 1);
                check("hold_dat", mdat, pdat);
                check("hold_addr", maddr, paddr);
            end
            if (mvld && mrdy) begin
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h want none",
                             maddr, mdat);
                end else begin
                    check("wr_addr", maddr, exp_addr.pop_front());
                    check("wr_dat", mdat, exp_dat.pop_front());
                end
            end
            if (done) begin
                check("done_pulse_width", pd, 0);
                done_cnt++;
            end
            pv = mvld;
            pr = mrdy;
            pd = done;
            pdat = mdat;
            paddr = maddr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        dat = x;
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic start(input int n, input int sh, input logic [15:0] base);
        cfg_out_num = 16'(n);
        cfg_shift = 5'(sh);
        cfg_base_addr = base;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Round-half-up then floor division by 2^sh, clamp to signed 8 bits.
    function automatic logic [7:0] quant(input longint x, input int sh);
        longint d;
        longint v;
        d = longint'(1) << sh;
        v = x + ((sh > 0) ? d / 2 : 0);
        if (v >= 0) v = v / d;
        else v = -((-v + d - 1) / d);
`ifdef YTYDLA_CACT_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic void model(input int xs[$], input int sh,
                                  input logic [15:0] base, input int maxw);
        logic [31:0] w;
        int wi;
        w = '0;
        wi = 0;
        foreach (xs[i]) begin
            w[8*(i%4) +: 8] = quant(longint'(xs[i]), sh);
            if ((i % 4) == 3 || i == xs.size() - 1) begin
                if (wi < maxw) begin
                    exp_addr.push_back(base + 16'(wi));
                    exp_dat.push_back(w);
                end
                wi++;
                w = '0;
            end
        end
    endfunction

    task automatic wait_done(input string nm, input int budget);
        bit got;
        int d0;
        got = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_all_written"}, exp_addr.size(), 0);
        check({nm, "_busy_in_done"}, busy, 1);
        @(negedge clk);
        #1;
        check({nm, "_idle_after"}, busy, 0);
        check({nm, "_one_done"}, done_cnt - d0, 1);
        exp_addr.delete();
        exp_dat.delete();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int xs[$];
        int lat;
        int sh;
        int n;
        logic [15:0] base;

        #12;
        check("rst_valid", mvld, 0);
        check("rst_dat", mdat, 0);
        check("rst_addr", maddr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        rdy_fix = 1'b1;
        tick();
        tick();

        // Four results, one full word, latency of the completing result.
        xs = '{400, 24, -32, 70000};
        model(xs, 4, 16'h0100, 8);
`ifdef YTYDLA_CACT_RELU_EN
        check("model_t1", exp_dat[0], 32'h7F000219);
`else
        check("model_t1", exp_dat[0], 32'h7FFE0219);
`endif
        start(4, 4, 16'h0100);
        send(400);
        send(24);
        send(-32);
        send(70000);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mvld) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 3);
        wait_done("t1", 200);
        check("t1_no_ovf", ovf, 0);

        // Full word followed by a partial word.
        xs = '{16, 32, 48, 64, 80, 96};
        model(xs, 4, 16'h0100, 8);
        check("model_t2_w0", exp_dat[0], 32'h04030201);
        check("model_t2_w1", exp_dat[1], 32'h00000605);
        check("model_t2_a1", exp_addr[1], 16'h0101);
        start(6, 4, 16'h0100);
        foreach (xs[i]) send(xs[i]);
        wait_done("t2", 200);

        // No consumer: eight words held, two dropped with addresses consumed.
        rdy_fix = 1'b0;
        tick();
        tick();
        xs.delete();
        for (int i = 0; i < 40; i++) xs.push_back(16);
        model(xs, 4, 16'h0100, 8);
        check("model_t3_last", exp_addr[7], 16'h0107);
        start(40, 4, 16'h0100);
        foreach (xs[i]) send(xs[i]);
        repeat (8) tick();
        check("t3_ovf_set", ovf, 1);
        check("t3_held", mvld, 1);
        rdy_fix = 1'b1;
        wait_done("t3", 300);
        check("t3_ovf_sticky", ovf, 1);

        // Stray valids in IDLE and a start during RUN are ignored.
        send(1000);
        tick();
        send(-5000);
        send(7);
        repeat (5) tick();
        check("t4_idle_novalid", mvld, 0);
        check("t4_idle_notbusy", busy, 0);
        xs = '{1, 2, 3, 4};
        model(xs, 0, 16'h0500, 8);
        check("model_t4", exp_dat[0], 32'h04030201);
        start(4, 0, 16'h0500);
        send(1);
        send(2);
        cfg_out_num = 16'd2;
        cfg_base_addr = 16'h0700;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send(3);
        send(4);
        wait_done("t4", 200);
        check("t4_ovf_cleared", ovf, 0);

        // Random layers with random backpressure and input gaps.
        rdy_rand = 1'b1;
        for (int layer = 0; layer < 2; layer++) begin
            n = (layer == 0) ? 64 : 37;
            sh = $urandom_range(0, 20);
            base = (layer == 0) ? 16'($urandom) : 16'hFFFE;
            xs.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) xs.push_back(int'($urandom));
                else xs.push_back($urandom_range(0, 8000) - 4000);
            end
            model(xs, sh, base, 64);
            if (layer == 1) check("model_wrap", exp_addr[2], 16'h0000);
            start(n, sh, base);
            for (int i = 0; i < n; ) begin
                if ($urandom_range(0, 1) == 1) begin
                    send(xs[i]);
                    i++;
                end else begin
                    tick();
                end
            end
            wait_done("rand", 2000);
            check("rand_no_ovf", ovf, 0);
        end
        rdy_rand = 1'b0;
        rdy_fix = 1'b0;
        tick();
        tick();

        // Reset in the middle of a layer with two words waiting.
        start(16, 4, 16'h0200);
        for (int i = 0; i < 8; i++) send(16);
        repeat (5) tick();
        check("t6_queued", mvld, 1);
        check("t6_head_addr", maddr, 16'h0200);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", mvld, 0);
        check("t6_rst_dat", mdat, 0);
        check("t6_rst_addr", maddr, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovf", ovf, 0);
        rdy_fix = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xs = '{16, 16, 16, 16};
        model(xs, 4, 16'h0300, 8);
        check("model_t6", exp_dat[0], 32'h01010101);
        start(4, 4, 16'h0300);
        check("t6_ovf_clear", ovf, 0);
        foreach (xs[i]) send(xs[i]);
        wait_done("t6", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
